// File: rtl/mem_copy_pkg.sv
// Shared types for the RC4 memory copy/fill engine.
// State and mode encodings used by the top and its next-state logic.
package mem_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_e;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } mode_e;

endpackage

// File: rtl/mem_copy_engine_next_state.sv
// Combinational next-state logic for the copy/fill engine.
// Reset priority is applied by the state register in the top.
module mem_copy_engine_next_state
  import mem_copy_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  state_e state_i,
  input  logic   start_i,
  input  logic   len_zero_i,
  input  mode_e  mode_i,
  input  logic   src_gnt_i,
  input  logic   dst_gnt_i,
  input  logic   lat_zero_i,
  input  logic   last_i,
  output state_e state_o
);

  logic gnt_ok;

  assign gnt_ok = dst_gnt_i &&
                  ((mode_i == FILL) || src_gnt_i);

  always_comb begin
    state_o = state_i;
    unique case (state_i)
      IDLE: begin
        if (start_i)
          state_o = len_zero_i ? DONE : WAIT_GRANT;
      end
      WAIT_GRANT: begin
        if (gnt_ok)
          state_o = (mode_i == COPY) ? READ : WRITE;
      end
      READ: begin
        state_o = (READ_LATENCY > 1) ? WAIT : WRITE;
      end
      WAIT: begin
        if (lat_zero_i)
          state_o = WRITE;
      end
      WRITE: begin
        if (last_i)
          state_o = DONE;
        else if (mode_i == COPY)
          state_o = READ;
      end
      DONE: begin
        if (!start_i)
          state_o = IDLE;
      end
      default: state_o = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_copy_engine.sv
// Memory-to-memory copy / constant fill engine with RAM arbitration.
// Config is latched on start; outputs decode from registered state.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int LEN_WIDTH    = 6,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  finish,
  output logic                  access_source_request,
  input  logic                  access_source_granted,
  output logic                  access_destination_request,
  input  logic                  access_destination_granted,
  output logic [ADDR_WIDTH-1:0] source_addr,
  input  logic [DATA_WIDTH-1:0] source_q,
  output logic [ADDR_WIDTH-1:0] destination_addr,
  output logic [DATA_WIDTH-1:0] destination_data,
  output logic                  destination_wren
);

  // WAIT lasts LAT_INIT+1 cycles, giving READ_LATENCY-1 in total
  localparam logic [1:0] LAT_INIT =
    (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic [1:0]            lat_q, lat_d;
  logic                  last_word;

  assign last_word = (cnt_q == len_q - LEN_WIDTH'(1));

  mem_copy_engine_next_state #(
    .READ_LATENCY(READ_LATENCY)
  ) u_next (
    .state_i    (state_q),
    .start_i    (start),
    .len_zero_i (length == '0),
    .mode_i     (mode_q),
    .src_gnt_i  (access_source_granted),
    .dst_gnt_i  (access_destination_granted),
    .lat_zero_i (lat_q == 2'd0),
    .last_i     (last_word),
    .state_o    (state_d)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    mode_d = mode_q;
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    fill_d = fill_q;
    lat_d  = lat_q;
    if (state_q == IDLE && start) begin
      mode_d = mode_e'(mode);
      src_d  = src_base;
      dst_d  = dst_base;
      len_d  = length;
      fill_d = fill_value;
      cnt_d  = '0;
    end
    if (state_q == READ)
      lat_d = LAT_INIT;
    if (state_q == WAIT)
      lat_d = lat_q - 2'd1;
    if (state_q == WRITE) begin
      src_d = src_q + ADDR_WIDTH'(1);
      dst_d = dst_q + ADDR_WIDTH'(1);
      cnt_d = cnt_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= COPY;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      fill_q <= '0;
      lat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      lat_q  <= lat_d;
    end
  end

  logic in_xfer;
  logic rd_phase;

  always_comb begin
    in_xfer  = (state_q == WAIT_GRANT) ||
               (state_q == READ) ||
               (state_q == WAIT) ||
               (state_q == WRITE);
    rd_phase = (mode_q == COPY) &&
               ((state_q == READ) ||
                (state_q == WAIT) ||
                (state_q == WRITE));
    busy                       = in_xfer;
    finish                     = (state_q == DONE);
    access_destination_request = in_xfer;
    access_source_request      = in_xfer &&
                                 (mode_q == COPY);
    source_addr      = '0;
    destination_addr = '0;
    destination_data = '0;
    destination_wren = 1'b0;
    if (rd_phase)
      source_addr = src_q;
    if (state_q == WRITE) begin
      destination_wren = 1'b1;
      destination_addr = dst_q;
      destination_data = (mode_q == COPY) ?
                         source_q : fill_q;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: one instance per read latency
// (1 and 3), each with its own source-RAM read pipeline.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] src_base = '0;
  logic [4:0] dst_base = '0;
  logic [5:0] length = '0;
  logic [7:0] fill_value = '0;
  logic       sgnt = 1'b0;
  logic       dgnt = 1'b0;

  logic       busy1, fin1, sreq1, dreq1, wren1;
  logic [4:0] saddr1, daddr1;
  logic [7:0] q1, ddata1;
  logic       busy3, fin3, sreq3, dreq3, wren3;
  logic [4:0] saddr3, daddr3;
  logic [7:0] q3, ddata3, p1, p2;

  logic [7:0] src_mem [32];
  int n_chk = 0;
  int n_fail = 0;
  int rises1 = 0;
  logic fin1_d = 1'b0;

  always #5 clk = ~clk;

  mem_copy_engine #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5),
    .LEN_WIDTH(6), .READ_LATENCY(1)
  ) u1 (
    .clk(clk), .reset(reset), .start(start1),
    .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .length(length),
    .fill_value(fill_value),
    .busy(busy1), .finish(fin1),
    .access_source_request(sreq1),
    .access_source_granted(sgnt),
    .access_destination_request(dreq1),
    .access_destination_granted(dgnt),
    .source_addr(saddr1), .source_q(q1),
    .destination_addr(daddr1),
    .destination_data(ddata1),
    .destination_wren(wren1)
  );

  mem_copy_engine #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5),
    .LEN_WIDTH(6), .READ_LATENCY(3)
  ) u3 (
    .clk(clk), .reset(reset), .start(start3),
    .mode(mode), .src_base(src_base),
    .dst_base(dst_base), .length(length),
    .fill_value(fill_value),
    .busy(busy3), .finish(fin3),
    .access_source_request(sreq3),
    .access_source_granted(sgnt),
    .access_destination_request(dreq3),
    .access_destination_granted(dgnt),
    .source_addr(saddr3), .source_q(q3),
    .destination_addr(daddr3),
    .destination_data(ddata3),
    .destination_wren(wren3)
  );

  always @(posedge clk) begin
    q1 <= src_mem[saddr1];
    p1 <= src_mem[saddr3];
    p2 <= p1;
    q3 <= p2;
    fin1_d <= fin1;
    if (fin1 && !fin1_d) rises1 <= rises1 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_chk++;
    if ({busy1, fin1, sreq1, dreq1, wren1,
         saddr1, daddr1, ddata1} !== '0) begin
      n_fail++;
      $display("FAIL reset_u1: got %0h want 0",
        {busy1, fin1, sreq1, dreq1, wren1,
         saddr1, daddr1, ddata1});
    end
    n_chk++;
    if ({busy3, fin3, sreq3, dreq3, wren3,
         saddr3, daddr3, ddata3} !== '0) begin
      n_fail++;
      $display("FAIL reset_u3: got %0h want 0",
        {busy3, fin3, sreq3, dreq3, wren3,
         saddr3, daddr3, ddata3});
    end
  endtask

  task automatic test_copy_full();
    int cyc = 0;
    int wr = 0;
    int bcy = 0;
    int r0;
    mode = 1'b0; src_base = 5'd0;
    dst_base = 5'd0; length = 6'd32;
    sgnt = 1'b1; dgnt = 1'b1;
    r0 = rises1;
    start1 = 1'b1;
    while (fin1 !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (busy1 === 1'b1) bcy++;
      if (wren1 === 1'b1 && wr < 32) begin
        n_chk++;
        if (daddr1 !== 5'(wr) ||
            ddata1 !== src_mem[wr]) begin
          n_fail++;
          $display("FAIL copy_word%0d: got %0h/%0h want %0h/%0h",
            wr, daddr1, ddata1, 5'(wr), src_mem[wr]);
        end
        wr++;
      end
    end
    n_chk++;
    if (cyc != 66) begin
      n_fail++;
      $display("FAIL copy_cycles: got %0d want 66", cyc);
    end
    n_chk++;
    if (wr != 32 || bcy != 65) begin
      n_fail++;
      $display("FAIL copy_counts: got wr=%0d busy=%0d want 32/65",
        wr, bcy);
    end
    repeat (3) tick();
    n_chk++;
    if (fin1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL copy_hold: got fin=%0b busy=%0b want 1/0",
        fin1, busy1);
    end
    start1 = 1'b0;
    tick();
    tick();
    n_chk++;
    if (fin1 !== 1'b0 || rises1 - r0 != 1) begin
      n_fail++;
      $display("FAIL copy_finish_once: got fin=%0b rises=%0d want 0/1",
        fin1, rises1 - r0);
    end
  endtask

  task automatic test_copy_wrap();
    int cyc = 0;
    int k;
    logic [4:0] ea;
    logic ew;
    mode = 1'b0; src_base = 5'd30;
    dst_base = 5'd5; length = 6'd4;
    sgnt = 1'b1; dgnt = 1'b1;
    start3 = 1'b1;
    while (fin3 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc >= 2 && cyc < 18) begin
        k = (cyc - 2) / 4;
        ea = 5'(30 + k);
        ew = ((cyc - 2) % 4 == 3);
        n_chk++;
        if (saddr3 !== ea || wren3 !== ew) begin
          n_fail++;
          $display("FAIL wrap_c%0d: got sa=%0d w=%0b want %0d/%0b",
            cyc, saddr3, wren3, ea, ew);
        end
        if (ew) begin
          n_chk++;
          if (daddr3 !== 5'(5 + k) ||
              ddata3 !== src_mem[ea]) begin
            n_fail++;
            $display("FAIL wrap_word%0d: got %0d/%0h want %0d/%0h",
              k, daddr3, ddata3, 5'(5 + k), src_mem[ea]);
          end
        end
      end
    end
    n_chk++;
    if (cyc != 18) begin
      n_fail++;
      $display("FAIL wrap_cycles: got %0d want 18", cyc);
    end
    start3 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fill();
    int cyc = 0;
    int sr = 0;
    mode = 1'b1; src_base = 5'd7;
    dst_base = 5'd10; length = 6'd6;
    fill_value = 8'hA5;
    sgnt = 1'b0; dgnt = 1'b1;
    start1 = 1'b1;
    while (fin1 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (sreq1 === 1'b1) sr++;
      if (cyc >= 2 && cyc < 8) begin
        n_chk++;
        if (wren1 !== 1'b1 ||
            daddr1 !== 5'(8 + cyc) ||
            ddata1 !== 8'hA5) begin
          n_fail++;
          $display("FAIL fill_c%0d: got %0b/%0d/%0h want 1/%0d/a5",
            cyc, wren1, daddr1, ddata1, 8 + cyc);
        end
      end
    end
    n_chk++;
    if (cyc != 8 || sr != 0) begin
      n_fail++;
      $display("FAIL fill_summary: got cyc=%0d sreq=%0d want 8/0",
        cyc, sr);
    end
    start1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_zero_len();
    mode = 1'b0; length = 6'd0;
    sgnt = 1'b1; dgnt = 1'b1;
    start1 = 1'b1;
    tick();
    n_chk++;
    if ({fin1, busy1, sreq1, dreq1, wren1} !== 5'b10000) begin
      n_fail++;
      $display("FAIL zero_done: got %b want 10000",
        {fin1, busy1, sreq1, dreq1, wren1});
    end
    repeat (3) tick();
    n_chk++;
    if (fin1 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_hold: got %0b want 1", fin1);
    end
    start1 = 1'b0;
    tick();
    n_chk++;
    if (fin1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: got %0b%0b want 00", fin1, busy1);
    end
  endtask

  task automatic test_grant_delay();
    int cyc = 0;
    int wr = 0;
    mode = 1'b0; src_base = 5'd3;
    dst_base = 5'd20; length = 6'd2;
    sgnt = 1'b0; dgnt = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if ({sreq1, dreq1, wren1, busy1} !== 4'b1101) begin
        n_fail++;
        $display("FAIL gnt_wait%0d: got %b want 1101",
          i, {sreq1, dreq1, wren1, busy1});
      end
    end
    sgnt = 1'b1;
    while (fin1 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (wren1 === 1'b1 && wr < 2) begin
        n_chk++;
        if (daddr1 !== 5'(20 + wr) ||
            ddata1 !== src_mem[3 + wr]) begin
          n_fail++;
          $display("FAIL gnt_word%0d: got %0d/%0h want %0d/%0h",
            wr, daddr1, ddata1, 20 + wr, src_mem[3 + wr]);
        end
        wr++;
      end
    end
    n_chk++;
    if (cyc != 5 || wr != 2) begin
      n_fail++;
      $display("FAIL gnt_summary: got cyc=%0d wr=%0d want 5/2",
        cyc, wr);
    end
    start1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int wr = 0;
    mode = 1'b0; src_base = 5'd0;
    dst_base = 5'd0; length = 6'd8;
    sgnt = 1'b1; dgnt = 1'b1;
    start1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (wren1 === 1'b1) wr++;
    end
    n_chk++;
    if (wren1 !== 1'b1 || wr != 3) begin
      n_fail++;
      $display("FAIL mid_third_write: got w=%0b n=%0d want 1/3",
        wren1, wr);
    end
    reset = 1'b1;
    start1 = 1'b0;
    tick();
    n_chk++;
    if ({busy1, fin1, sreq1, dreq1, wren1,
         saddr1, daddr1, ddata1} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got %0h want 0",
        {busy1, fin1, sreq1, dreq1, wren1,
         saddr1, daddr1, ddata1});
    end
    reset = 1'b0;
    tick();
    src_base = 5'd12; dst_base = 5'd1;
    length = 6'd3;
    start1 = 1'b1;
    wr = 0;
    while (fin1 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (wren1 === 1'b1 && wr < 3) begin
        n_chk++;
        if (daddr1 !== 5'(1 + wr) ||
            ddata1 !== src_mem[12 + wr]) begin
          n_fail++;
          $display("FAIL mid_word%0d: got %0d/%0h want %0d/%0h",
            wr, daddr1, ddata1, 1 + wr, src_mem[12 + wr]);
        end
        wr++;
      end
    end
    n_chk++;
    if (cyc != 8 || wr != 3) begin
      n_fail++;
      $display("FAIL mid_restart: got cyc=%0d wr=%0d want 8/3",
        cyc, wr);
    end
    start1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      src_mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_copy_full();
    test_copy_wrap();
    test_fill();
    test_zero_len();
    test_grant_delay();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Parametrised memory-to-memory transfer engine for the RC4 decoder datapath. It moves `length` words from a source RAM window to a destination RAM window, or fills a destination window with a constant. Base addresses, data and address widths, and source read latency are all configurable. It arbitrates for both RAMs through request/grant pairs, reports `busy`/`finish`, and re-arms without a global reset.

## Interface
Parameters:
- DATA_WIDTH, 8, word width of both RAMs
- ADDR_WIDTH, 5, address width of both RAMs
- LEN_WIDTH, 6, width of `length` (must be ≥ ADDR_WIDTH+1 so a full RAM fits)
- READ_LATENCY, 1, cycles from `source_addr` to valid `source_q`; legal values are 1..3

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  level request to begin a transfer
- mode  in  1  0 = COPY, 1 = FILL
- src_base  in  ADDR_WIDTH  first source address
- dst_base  in  ADDR_WIDTH  first destination address
- length  in  LEN_WIDTH  word count; 0 = no-op
- fill_value  in  DATA_WIDTH  constant written in FILL mode
- busy  out  1  high from leaving IDLE until entering DONE
- finish  out  1  high while in DONE
- access_source_request / access_source_granted  out/in  1  source RAM arbitration
- access_destination_request / access_destination_granted  out/in  1  destination RAM arbitration
- source_addr  out  ADDR_WIDTH; source_q  in  DATA_WIDTH
- destination_addr  out  ADDR_WIDTH; destination_data  out  DATA_WIDTH; destination_wren  out  1

## Operation
- Reset values: all outputs 0; the pointers, word count and latency counter are 0; the state is IDLE.
- IDLE: when `start`=1, register `mode`, `src_base`, `dst_base`, `length` and `fill_value`. Later changes to these inputs are ignored until the next IDLE.
  - If `length`=0, go to DONE with no request raised.
  - Otherwise go to WAIT_GRANT.
- WAIT_GRANT: raise `access_destination_request`, plus `access_source_request` in COPY mode only.
  - Advance when every raised request is granted: to READ in COPY mode, to WRITE in FILL mode.
- READ (COPY only): drive `source_addr` = src pointer, then go to WAIT.
- WAIT: hold the address for READ_LATENCY−1 cycles using a down-counter. When READ_LATENCY=1, WAIT is skipped.
- WRITE: `destination_wren`=1 and `destination_addr` = dst pointer.
  - `destination_data` = `source_q` in COPY mode, registered `fill_value` in FILL mode.
  - Then increment both pointers and the word count.
  - If the count equals `length`−1, go to DONE; otherwise go to READ (COPY) or stay in WRITE (FILL).
- DONE: drop both requests, `finish`=1. Return to IDLE when `start`=0, so a held `start` does not retrigger.
- Requests stay high continuously from WAIT_GRANT through the last WRITE. The arbiter must not revoke a grant while the request is high; grants are sampled only in WAIT_GRANT.
- Pointers wrap modulo 2^ADDR_WIDTH. A window crossing the top address continues at 0.
- Overlapping source and destination windows are copied in ascending order with no hazard protection.
- `source_addr` is held through WAIT and WRITE of the same word.
- Reset has priority over every transition. Reset mid-transfer drops requests and `wren` the next cycle; partial writes remain in the destination RAM.

## Timing
- COPY: READ_LATENCY+1 cycles per word. Total = 1 (IDLE) + grant wait + length×(READ_LATENCY+1), then DONE.
- FILL: 1 cycle per word, back-to-back `wren`.
- `start`→`busy`: 1 cycle. Last WRITE→`finish`: 1 cycle.
- All outputs are decoded from registered state and pointers; there is no combinational path from inputs to outputs, except `destination_data` = `source_q` in COPY mode.

## Structure
- Package `mem_copy_pkg`: state enum (IDLE, WAIT_GRANT, READ, WAIT, WRITE, DONE) and mode enum (COPY, FILL).
- Sub-module `mem_copy_engine_next_state`: purely combinational next-state logic. Pointers, counters and registered config live in the top module.

## Test plan
- COPY, src_base=0, dst_base=0, length=32, READ_LATENCY=1, grants immediate → dest[i]=src[i] for all 32 words; 64 transfer cycles; `finish` rises once.
- COPY, src_base=30, dst_base=5, length=4, READ_LATENCY=3 → reads 30, 31, 0, 1 write dest 5..8; 4 cycles per word; `source_addr` is stable across each word.
- FILL, dst_base=10, length=6, fill_value=0xA5 → `wren` high for 6 consecutive cycles on 10..15; `access_source_request` never asserts.
- length=0 with `start` → DONE after 1 cycle with no request; holding `start` keeps `finish`=1; dropping `start` returns to IDLE.
- Source grant delayed 5 cycles → no READ/WRITE until both grants are high; then a normal transfer.
- Reset asserted during the 3rd WRITE of a length=8 COPY → next cycle all outputs are 0 and the state is IDLE; a new `start` completes a fresh transfer correctly.
